// File: rtl/step_player.sv
// Drum sequencer datapath: pattern/tempo registers, eighth-note tick generator,
// per-instrument trigger pulses and timed gates driven by the FSM beat index.
module step_player #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned GATE_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       ld_ins1,
  input  logic       ld_ins2,
  input  logic       ld_ins3,
  input  logic       ld_ins4,
  input  logic       ld_bpm,
  input  logic       play,
  input  logic [2:0] timing,
  output logic       step_tick,
  output logic [3:0] trig,
  output logic [3:0] gate,
  output logic [7:0] bpm,
  output logic [7:0] beat_led
);

  localparam int unsigned THRESH   = CLK_HZ * 30;
  localparam int unsigned CW       = $clog2(GATE_CYCLES + 1);
  localparam logic [32:0] THRESH_W = 33'(THRESH);
  localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES);

  logic [3:0][7:0]    pat;
  logic [31:0]        acc;
  logic [32:0]        sum;
  logic [2:0]         timing_q;
  logic               play_q;
  logic               new_step;
  logic [3:0]         hit;
  logic [3:0][CW-1:0] cnt;

  // Tick accumulator sum is one bit wider so a threshold near 2^32 cannot wrap.
  always_comb begin
    sum      = {1'b0, acc} + 33'(bpm);
    new_step = play & ((timing != timing_q) | ~play_q);
    hit      = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = new_step & pat[i][timing];
    end
    beat_led = play ? (8'b1 << timing) : 8'b0;
  end

  // Pattern/tempo registers, tick generator and step-detect history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat       <= '0;
      bpm       <= 8'd120;
      acc       <= '0;
      step_tick <= 1'b0;
      trig      <= '0;
      timing_q  <= '0;
      play_q    <= 1'b0;
    end else begin
      if (ld_ins1) pat[0] <= data_in;
      if (ld_ins2) pat[1] <= data_in;
      if (ld_ins3) pat[2] <= data_in;
      if (ld_ins4) pat[3] <= data_in;
      if (ld_bpm && (data_in != 8'd0)) bpm <= data_in;
      if (sum >= THRESH_W) begin
        acc       <= 32'(sum - THRESH_W);
        step_tick <= 1'b1;
      end else begin
        acc       <= sum[31:0];
        step_tick <= 1'b0;
      end
      trig     <= hit;
      timing_q <= timing;
      play_q   <= play;
    end
  end

  // Gates rise with the trigger and stay high for GATE_CYCLES cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset || !play) begin
        cnt[i]  <= '0;
        gate[i] <= 1'b0;
      end else if (hit[i]) begin
        cnt[i]  <= GATE_LOAD;
        gate[i] <= 1'b1;
      end else if (cnt[i] != '0) begin
        cnt[i]  <= cnt[i] - CW'(1);
        gate[i] <= (cnt[i] != CW'(1));
      end else begin
        gate[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_player.sv
// Bench for step_player: directed tables/sequences plus random traffic,
// all cycles compared against a beat/tick reference model.
module tb_step_player;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned GATE   = 10;
  localparam longint      THRESH = 30000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm;
  logic       play;
  logic [2:0] timing;
  logic       step_tick;
  logic [3:0] trig, gate;
  logic [7:0] bpm, beat_led;

  int n_total = 0;
  int n_pass  = 0;

  step_player #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(GATE)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .ld_ins1(ld_ins1), .ld_ins2(ld_ins2), .ld_ins3(ld_ins3), .ld_ins4(ld_ins4),
    .ld_bpm(ld_bpm), .play(play), .timing(timing),
    .step_tick(step_tick), .trig(trig), .gate(gate), .bpm(bpm), .beat_led(beat_led)
  );

  always #5 clk = ~clk;

  // Reference model: ticks from the total tempo credit since reset, gates from
  // the cycle number of the most recent hit.
  longint     cyc, s_total, prev;
  logic       m_tick;
  logic [7:0] m_pat [4];
  logic [7:0] m_bpm;
  logic [2:0] m_tq;
  logic       m_pq;
  logic [3:0] m_trig;
  longint     last_hit [4];
  logic       ns;

  always @(posedge clk) begin
    if (!reset) begin
      cyc = 0; s_total = 0; m_tick = 1'b0; m_bpm = 8'd120;
      m_tq = 3'd0; m_pq = 1'b0; m_trig = 4'b0;
      for (int i = 0; i < 4; i++) begin m_pat[i] = 8'h00; last_hit[i] = -1; end
    end else begin
      cyc++;
      prev    = s_total;
      s_total = s_total + longint'(m_bpm);
      m_tick  = (s_total / THRESH) != (prev / THRESH);
      ns = play && ((timing != m_tq) || !m_pq);
      for (int i = 0; i < 4; i++) begin
        m_trig[i] = ns && m_pat[i][timing];
        if (m_trig[i]) last_hit[i] = cyc;
        if (!play) last_hit[i] = -1;
      end
      if (ld_ins1) m_pat[0] = data_in;
      if (ld_ins2) m_pat[1] = data_in;
      if (ld_ins3) m_pat[2] = data_in;
      if (ld_ins4) m_pat[3] = data_in;
      if (ld_bpm && data_in != 8'd0) m_bpm = data_in;
      m_tq = timing;
      m_pq = play;
    end
  end

  function automatic logic [3:0] exp_gate();
    logic [3:0] g;
    for (int i = 0; i < 4; i++)
      g[i] = (last_hit[i] >= 0) && (cyc - last_hit[i] < longint'(GATE));
    return g;
  endfunction

  function automatic logic [7:0] exp_led(input logic p, input logic [2:0] t);
    logic [7:0] one;
    one = 8'd1;
    return p ? (one << t) : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance one clock and compare all outputs with the model at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    chk("model_tick", 32'(step_tick), 32'(m_tick));
    chk("model_trig", 32'(trig), 32'(m_trig));
    chk("model_gate", 32'(gate), 32'(exp_gate()));
    chk("model_bpm",  32'(bpm), 32'(m_bpm));
    chk("model_led",  32'(beat_led), 32'(exp_led(play, timing)));
  endtask

  task automatic idle_loads();
    ld_ins1 = 0; ld_ins2 = 0; ld_ins3 = 0; ld_ins4 = 0; ld_bpm = 0;
  endtask

  typedef struct {
    logic       p;
    logic [2:0] t;
    logic [3:0] exp_trig;
  } vec_t;

  vec_t   tbl [13];
  longint q[$];
  int     cnt;

  initial begin
    reset = 0; data_in = 0; play = 0; timing = 0;
    idle_loads();
    @(negedge clk);
    repeat (3) cycle();
    chk("rst_tick", 32'(step_tick), 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_gate", 32'(gate), 0);
    chk("rst_bpm",  32'(bpm), 120);

    // Default tempo: ticks every 250 cycles.
    reset = 1;
    for (int n = 1; n <= 760; n++) begin
      cycle();
      if (step_tick) q.push_back(n);
    end
    chk("tick_count_120", 32'(q.size()), 3);
    if (q.size() == 3) begin
      chk("tick1_120", 32'(q[0]), 250);
      chk("tick2_120", 32'(q[1]), 500);
      chk("tick3_120", 32'(q[2]), 750);
    end

    // Tempo 200: exact 150-cycle spacing once the residue settles.
    ld_bpm = 1; data_in = 8'd200;
    cycle();
    idle_loads();
    chk("bpm_load_200", 32'(bpm), 200);
    q.delete();
    for (int n = 1; n <= 1500; n++) begin
      cycle();
      if (step_tick) q.push_back(n);
    end
    chk("tick_count_200", 32'(q.size() >= 9 && q.size() <= 11), 1);
    if (q.size() >= 3) chk("tick_spacing_200", 32'(q[2] - q[1]), 150);
    else chk("tick_spacing_200", 0, 150);
    ld_bpm = 1; data_in = 8'd0;
    cycle();
    idle_loads();
    chk("bpm_zero_reject", 32'(bpm), 200);

    // Pattern hits across a full beat loop including play rise and wrap.
    ld_ins1 = 1; data_in = 8'b0000_0101; cycle();
    idle_loads(); ld_ins3 = 1; data_in = 8'hFF; cycle();
    idle_loads();
    tbl[0]  = '{1'b0, 3'd0, 4'b0000};
    tbl[1]  = '{1'b1, 3'd0, 4'b0101};
    tbl[2]  = '{1'b1, 3'd0, 4'b0000};
    for (int k = 1; k < 8; k++)
      tbl[2 + k] = '{1'b1, 3'(k), (k == 2) ? 4'b0101 : 4'b0100};
    tbl[10] = '{1'b1, 3'd0, 4'b0101};
    tbl[11] = '{1'b1, 3'd0, 4'b0000};
    tbl[12] = '{1'b0, 3'd0, 4'b0000};
    foreach (tbl[k]) begin
      play = tbl[k].p; timing = tbl[k].t;
      #1 chk("tbl_led", 32'(beat_led), 32'(exp_led(tbl[k].p, tbl[k].t)));
      cycle();
      chk("tbl_trig", 32'(trig), 32'(tbl[k].exp_trig));
    end

    // Load on the same edge as a step: trigger sees the old pattern.
    play = 1; timing = 3'd1; cycle();
    chk("pre_load_trig", 32'(trig), 32'(4'b0100));
    ld_ins1 = 1; data_in = 8'hFF; timing = 3'd3; cycle();
    idle_loads();
    chk("old_pat_trig", 32'(trig[0]), 0);
    timing = 3'd4; cycle();
    chk("new_pat_trig", 32'(trig[0]), 1);
    ld_ins1 = 1; data_in = 8'b0000_0101; cycle();
    idle_loads();

    // Single hit: gate high for exactly GATE cycles.
    play = 0; timing = 0; repeat (2) cycle();
    play = 1; cycle();
    chk("gate_hit_trig", 32'(trig), 32'(4'b0101));
    cnt = int'(gate[0]);
    for (int k = 1; k <= 15; k++) begin cycle(); cnt += int'(gate[0]); end
    chk("gate_len_single", 32'(cnt), 10);

    // Retrigger at cycle 6 stretches the gate to 16 cycles.
    play = 0; repeat (2) cycle();
    play = 1; cycle();
    cnt = int'(gate[0]);
    for (int k = 1; k <= 25; k++) begin
      cycle();
      cnt += int'(gate[0]);
      if (k == 6) chk("retrig_trig", 32'(trig[0]), 1);
      if (k == 5) timing = 3'd2;
    end
    chk("gate_len_retrig", 32'(cnt), 16);

    // Play drop at cycle 3 clears the gate at cycle 4.
    play = 0; timing = 0; repeat (2) cycle();
    play = 1; cycle();
    repeat (3) cycle();
    chk("gate_before_drop", 32'(gate[0]), 1);
    play = 0;
    #1 chk("led_drop", 32'(beat_led), 0);
    cycle();
    chk("gate_after_drop", 32'(gate), 0);
    chk("trig_after_drop", 32'(trig), 0);

    // Reset in the middle of a gate with a non-default tempo.
    ld_bpm = 1; data_in = 8'd200; cycle();
    idle_loads();
    play = 1; cycle();
    chk("gate_pre_reset", 32'(gate[0]), 1);
    reset = 0; ld_ins2 = 1; data_in = 8'hAA; cycle();
    idle_loads();
    chk("rst2_trig", 32'(trig), 0);
    chk("rst2_gate", 32'(gate), 0);
    chk("rst2_tick", 32'(step_tick), 0);
    chk("rst2_bpm",  32'(bpm), 120);
    reset = 1; play = 0;
    q.delete();
    for (int n = 1; n <= 300; n++) begin
      cycle();
      if (step_tick) q.push_back(n);
    end
    chk("rst2_first_tick", 32'(q.size() > 0 ? q[0] : 0), 250);

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      ld_ins1 = ($urandom_range(0, 19) == 0);
      ld_ins2 = ($urandom_range(0, 19) == 0);
      ld_ins3 = ($urandom_range(0, 19) == 0);
      ld_ins4 = ($urandom_range(0, 19) == 0);
      ld_bpm  = ($urandom_range(0, 49) == 0);
      data_in = 8'($urandom);
      if (ld_bpm && $urandom_range(0, 3) == 0) data_in = 8'd0;
      if (r < 3) play = ~play;
      else if (r < 30) timing = timing + 3'd1;
      else if (r < 33) timing = 3'($urandom);
      if (k % 400 == 0) play = 1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
